right_shift_seq: RTL and testbench

- Multi-cycle right shifter, the counterpart of the team's combinational left logic shift in the lab1 ALU datapath.
- Takes a WIDTH-bit operand and shift amount on a start pulse, shifts one bit per clock, and reports the result with a one-cycle done strobe.
- LOST flag is the right-shift analogue of the left shifter's OF: it reports whether any 1 bits were shifted out.
- Used by the ALU controller when a registered, low-area shift is acceptable.

---
 rtl/right_shift_seq_if.sv | 33 +++
 rtl/right_shift_seq.sv | 139 +++++++++++++
 tb/tb_right_shift_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/right_shift_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : right_shift_seq_if
// Description : Request/result bundle for the multi-cycle right shifter.
//               The master issues start/operand/mode. The slave returns the
//               result, the LOST flag, busy and the done strobe.
// Revision    : 1.0 - initial release
// ============================================================================
interface right_shift_seq_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   SH;
  logic             ARITH;
  logic             ROT;
  logic [WIDTH-1:0] Y;
  logic             LOST;
  logic             busy;
  logic             done;

  modport master (
    output start, A, SH, ARITH, ROT,
    input  Y, LOST, busy, done
  );

  modport slave (
    input  start, A, SH, ARITH, ROT,
    output Y, LOST, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/right_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : right_shift_seq
// Description : Multi-cycle right shifter. It shifts one bit per clock and
//               supports logical or arithmetic fill. Y is the result. LOST is
//               set when any 1 bit was shifted out. done pulses for one cycle
//               when Y and LOST become valid.
//               Optional macro ROTATE_EN: builds the rotate-right mode, which
//               is selected by ROT. When the macro is undefined, ROT is
//               ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module right_shift_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  right_shift_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [SHW-1:0] c_ONE = {{(SHW-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [SHW-1:0]   count_q, count_d;
  logic             lost_q,  lost_d;   // running OR of bits shifted out
  logic             arith_q, arith_d;
  logic             rot_q,   rot_d;
  logic [WIDTH-1:0] y_q,     y_d;      // published result
  logic             lsto_q,  lsto_d;   // published LOST

  logic             w_fill;
  logic             w_lost_bit;
  logic [WIDTH-1:0] w_shifted;

  // Select the MSB fill bit and the loss contribution for the current mode.
`ifdef ROTATE_EN
  always_comb begin
    w_fill     = rot_q ? work_q[0] : (arith_q ? work_q[WIDTH-1] : 1'b0);
    w_lost_bit = rot_q ? 1'b0 : work_q[0];
  end
`else
  always_comb begin
    w_fill     = arith_q ? work_q[WIDTH-1] : 1'b0;
    w_lost_bit = work_q[0];
  end
`endif

  assign w_shifted = {w_fill, work_q[WIDTH-1:1]};

  // Next-state logic: capture on start, shift in SHIFT, and publish on entry
  // to DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    lost_d  = lost_q;
    arith_d = arith_q;
    rot_d   = rot_q;
    y_d     = y_q;
    lsto_d  = lsto_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          work_d  = bus.A;
          count_d = bus.SH;
          arith_d = bus.ARITH;
`ifdef ROTATE_EN
          rot_d   = bus.ROT;
`else
          rot_d   = 1'b0;
`endif
          lost_d  = 1'b0;
          if (bus.SH == '0) begin
            // A zero shift publishes the operand unchanged.
            state_d = S_DONE;
            y_d     = bus.A;
            lsto_d  = 1'b0;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d  = w_shifted;
        lost_d  = lost_q | w_lost_bit;
        count_d = count_q - c_ONE;
        if (count_q == c_ONE) begin
          state_d = S_DONE;
          y_d     = w_shifted;
          lsto_d  = lost_q | w_lost_bit;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      count_q <= '0;
      lost_q  <= 1'b0;
      arith_q <= 1'b0;
      rot_q   <= 1'b0;
      y_q     <= '0;
      lsto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      lost_q  <= lost_d;
      arith_q <= arith_d;
      rot_q   <= rot_d;
      y_q     <= y_d;
      lsto_q  <= lsto_d;
    end
  end

  assign bus.Y    = y_q;
  assign bus.LOST = lsto_q;
  assign bus.busy = (state_q == S_SHIFT);
  assign bus.done = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_right_shift_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_right_shift_seq
// Description : Scoreboard bench for right_shift_seq. It drives directed
//               operations with hand-computed results. A monitor checks the
//               outputs on every done strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_right_shift_seq;

  typedef struct {
    logic [15:0] y;
    logic        lost;
    string       name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   pushes;
  int   dones;
  exp_t sb_q[$];

  right_shift_seq_if #(.WIDTH(16), .SHW(4)) bus ();

  right_shift_seq #(.WIDTH(16), .SHW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: on each done strobe, pop the oldest expectation and compare.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      dones++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, ".Y"}, {16'h0, bus.Y}, {16'h0, e.y});
        check({e.name, ".LOST"}, {31'h0, bus.LOST}, {31'h0, e.lost});
      end
    end
  end

  task automatic run_op(input string name, input logic [15:0] a, input logic [3:0] sh,
                        input logic arith, input logic rot,
                        input logic [15:0] ey, input logic el, input bit restart);
    int cyc;
    int bcnt;
    bit got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = a;
    bus.SH    = sh;
    bus.ARITH = arith;
    bus.ROT   = rot;
    sb_q.push_back('{ey, el, name});
    pushes++;
    @(negedge clk);
    // Captured inputs must not matter after the accepting edge.
    bus.start = 1'b0;
    bus.A     = 16'($urandom);
    bus.SH    = 4'($urandom);
    bus.ARITH = ~arith;
    bus.ROT   = ~rot;
    cyc  = 1;
    bcnt = 0;
    got  = 1'b0;
    while (!got && cyc <= 40) begin
      if (bus.busy === 1'b1) bcnt++;
      if (bus.done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (restart && cyc == 2) begin
          bus.start = 1'b1;
          bus.A     = 16'hFFFF;
          bus.SH    = 4'd1;
        end else begin
          bus.start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.start = 1'b0;
    check({name, ".done_seen"}, {31'h0, got}, 32'd1);
    check({name, ".latency"}, cyc, sh + 32'd1);
    check({name, ".busy_cycles"}, bcnt, {28'h0, sh});
    repeat (2) @(negedge clk);
    check({name, ".Y_hold"}, {16'h0, bus.Y}, {16'h0, ey});
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    pushes = 0;
    dones  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.SH    = '0;
    bus.ARITH = 1'b0;
    bus.ROT   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.Y", {16'h0, bus.Y}, 32'h0);
    check("reset.LOST", {31'h0, bus.LOST}, 32'h0);
    check("reset.busy", {31'h0, bus.busy}, 32'h0);
    check("reset.done", {31'h0, bus.done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("logical",   16'h1230, 4'd4,  1'b0, 1'b0, 16'h0123, 1'b0, 1'b0);
    run_op("lsr_8001",  16'h8001, 4'd4,  1'b0, 1'b0, 16'h0800, 1'b1, 1'b0);
    run_op("asr_8001",  16'h8001, 4'd4,  1'b1, 1'b0, 16'hF800, 1'b1, 1'b0);
    run_op("zero_sh",   16'hBEEF, 4'd0,  1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
    run_op("busy_start",16'h00FF, 4'd8,  1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("asr_max",   16'h8000, 4'd15, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    run_op("lsr_max",   16'h8000, 4'd15, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
`ifdef ROTATE_EN
    run_op("rotate",    16'h000F, 4'd4,  1'b0, 1'b1, 16'hF000, 1'b0, 1'b0);
    run_op("rot_prio",  16'h0003, 4'd1,  1'b1, 1'b1, 16'h8001, 1'b0, 1'b0);
`else
    run_op("rotate",    16'h000F, 4'd4,  1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("rot_prio",  16'h0003, 4'd1,  1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
`endif

    // Reset in the middle of a shift, with a nonzero result already published.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 16'h1234;
    bus.SH    = 4'd8;
    bus.ARITH = 1'b0;
    bus.ROT   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst.busy_before", {31'h0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.Y", {16'h0, bus.Y}, 32'h0);
    check("midrst.LOST", {31'h0, bus.LOST}, 32'h0);
    check("midrst.busy", {31'h0, bus.busy}, 32'h0);
    check("midrst.done", {31'h0, bus.done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 16'h0010, 4'd4, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("done_count", dones, pushes);
    check("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
